seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 215 +++++++++++++++++++++
 tb/tb_seg7_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture
//  Purpose  : Samples an active-low 7-segment LED pattern, waits for it to be
//             stable for STABLE_CYCLES samples, decodes it to a hex digit and
//             offers the result on a valid/ready handshake. Unrecognised
//             patterns are offered with an error flag and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_capture #(
   // Consecutive identical samples needed before a pattern is accepted (1..255)
   parameter int STABLE_CYCLES = 4,
   // Width of the saturating error counter
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       leds,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [3:0]       out_bcd,
   output logic             out_err,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0]       S_WAIT    = 2'd0;
   localparam logic [1:0]       S_SETTLE  = 2'd1;
   localparam logic [1:0]       S_OFFER   = 2'd2;

   localparam logic [6:0]       PAT_BLANK = 7'h7F;
   localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0] state;
   logic [1:0] next_state;
   logic [6:0] leds_q;     // input sample, the only consumer of leds
   logic [6:0] last_pat;   // most recently delivered (or blanked) pattern
   logic [6:0] cand;       // pattern currently being qualified
   logic [7:0] cnt;        // number of consecutive samples equal to cand

   // Decoder results for the candidate pattern
   logic [3:0] dec_digit;
   logic       dec_valid;
   logic       dec_blank;

   // Control strobes derived from state and datapath
   logic start;            // WAIT sees a pattern different from last_pat
   logic restart;          // SETTLE sees the candidate change
   logic inc;              // SETTLE sees the candidate repeat
   logic accept;           // candidate has been stable long enough
   logic is_dup;           // accepted candidate equals the prior pattern
   logic emit;             // accepted candidate produces a result
   logic blank_accept;     // accepted candidate is the blank pattern
   logic handshake;        // consumer takes the offered result

   // ------------------------------------------------------------------------
   // Inverse hex-to-7-segment table; anything not listed is invalid
   // ------------------------------------------------------------------------
   always_comb begin
      dec_digit = 4'h0;
      dec_valid = 1'b1;
      case (cand)
         7'h40:   dec_digit = 4'h0;
         7'h79:   dec_digit = 4'h1;
         7'h24:   dec_digit = 4'h2;
         7'h30:   dec_digit = 4'h3;
         7'h19:   dec_digit = 4'h4;
         7'h12:   dec_digit = 4'h5;
         7'h02:   dec_digit = 4'h6;
         7'h78:   dec_digit = 4'h7;
         7'h00:   dec_digit = 4'h8;
         7'h10:   dec_digit = 4'h9;
         7'h08:   dec_digit = 4'hA;
         7'h03:   dec_digit = 4'hB;
         7'h46:   dec_digit = 4'hC;
         7'h21:   dec_digit = 4'hD;
         7'h06:   dec_digit = 4'hE;
         7'h0E:   dec_digit = 4'hF;
         default: dec_valid = 1'b0;
      endcase
      dec_blank = (cand == PAT_BLANK);
   end

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_WAIT;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         S_WAIT: begin
            if (start) begin
               next_state = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (accept) begin
               next_state = emit ? S_OFFER : S_WAIT;
            end
         end
         S_OFFER: begin
            if (handshake) begin
               next_state = S_WAIT;
            end
         end
         default: next_state = S_WAIT;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM outputs: control strobes and busy flag
   // A candidate that has reached the stability count is accepted on that
   // edge even if the sample has just moved; the new sample is then picked
   // up again from WAIT, so nothing is lost.
   // ------------------------------------------------------------------------
   always_comb begin
      start        = (state == S_WAIT) && (leds_q != last_pat);
      accept       = (state == S_SETTLE) && (cnt >= STABLE_LIM);
      restart      = (state == S_SETTLE) && !accept && (leds_q != cand);
      inc          = (state == S_SETTLE) && !accept && (leds_q == cand);
      is_dup       = (cand == last_pat);
      emit         = accept && !is_dup && !dec_blank;
      blank_accept = accept && !is_dup && dec_blank;
      handshake    = (state == S_OFFER) && out_valid && out_ready;
      busy         = (state != S_WAIT);
   end

   // ------------------------------------------------------------------------
   // Input sampling register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds_q <= PAT_BLANK;
      end else begin
         leds_q <= leds;
      end
   end

   // ------------------------------------------------------------------------
   // Candidate pattern and stability counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand <= PAT_BLANK;
         cnt  <= 8'd0;
      end else if (start || restart) begin
         cand <= leds_q;
         cnt  <= 8'd1;
      end else if (inc) begin
         cnt  <= cnt + 8'd1;
      end else if (accept) begin
         cnt  <= 8'd0;
      end
   end

   // ------------------------------------------------------------------------
   // Last delivered pattern: updated on blank acceptance or handshake
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_pat <= PAT_BLANK;
      end else if (blank_accept) begin
         last_pat <= PAT_BLANK;
      end else if (handshake) begin
         last_pat <= cand;
      end
   end

   // ------------------------------------------------------------------------
   // Result registers; bcd/err hold their value after the handshake
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_bcd   <= 4'h0;
         out_err   <= 1'b0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_bcd   <= dec_valid ? dec_digit : 4'h0;
         out_err   <= !dec_valid;
      end else if (handshake) begin
         out_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Saturating count of emitted invalid patterns
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (emit && !dec_valid && (err_count != ERR_MAX)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture
//  Purpose  : Self-checking bench for seg7_capture: table of single patterns
//             plus directed sequences for back-pressure, glitches, blanking,
//             error saturation and reset during an offer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [6:0] leds = 7'h7F;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [3:0] out_bcd;
   logic       out_err;
   logic [7:0] err_count;
   logic       busy;

   logic [6:0] leds2 = 7'h7F;
   logic       ready2 = 1'b1;
   logic       valid2;
   logic [3:0] bcd2;
   logic       err2;
   logic [1:0] ecnt2;
   logic       busy2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_capture #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .leds(leds), .out_ready(out_ready),
      .out_valid(out_valid), .out_bcd(out_bcd), .out_err(out_err),
      .err_count(err_count), .busy(busy)
   );

   seg7_capture #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .leds(leds2), .out_ready(ready2),
      .out_valid(valid2), .out_bcd(bcd2), .out_err(err2),
      .err_count(ecnt2), .busy(busy2)
   );

   typedef struct {
      logic [6:0] pat;
      logic       emit;
      logic [3:0] bcd;
      logic       err;
      logic [7:0] ecnt;
   } vec_t;

   vec_t tbl[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid on dut; returns the edge index it was seen on, 0 on timeout
   task automatic wait_valid(input int max_edges, output int edge_no);
      edge_no = 0;
      for (int i = 1; i <= max_edges; i++) begin
         step();
         if (out_valid) begin
            edge_no = i;
            return;
         end
      end
   endtask

   initial begin
      int e;
      int seen_v;
      int seen_b;
      int n_emit;
      logic [6:0] bad_pats [5];

      tbl[0]  = '{7'h30, 1'b1, 4'h3, 1'b0, 8'd0};
      tbl[1]  = '{7'h40, 1'b1, 4'h0, 1'b0, 8'd0};
      tbl[2]  = '{7'h79, 1'b1, 4'h1, 1'b0, 8'd0};
      tbl[3]  = '{7'h24, 1'b1, 4'h2, 1'b0, 8'd0};
      tbl[4]  = '{7'h19, 1'b1, 4'h4, 1'b0, 8'd0};
      tbl[5]  = '{7'h12, 1'b1, 4'h5, 1'b0, 8'd0};
      tbl[6]  = '{7'h02, 1'b1, 4'h6, 1'b0, 8'd0};
      tbl[7]  = '{7'h78, 1'b1, 4'h7, 1'b0, 8'd0};
      tbl[8]  = '{7'h00, 1'b1, 4'h8, 1'b0, 8'd0};
      tbl[9]  = '{7'h10, 1'b1, 4'h9, 1'b0, 8'd0};
      tbl[10] = '{7'h08, 1'b1, 4'hA, 1'b0, 8'd0};
      tbl[11] = '{7'h03, 1'b1, 4'hB, 1'b0, 8'd0};
      tbl[12] = '{7'h46, 1'b1, 4'hC, 1'b0, 8'd0};
      tbl[13] = '{7'h21, 1'b1, 4'hD, 1'b0, 8'd0};
      tbl[14] = '{7'h06, 1'b1, 4'hE, 1'b0, 8'd0};
      tbl[15] = '{7'h7E, 1'b1, 4'h0, 1'b1, 8'd1};
      tbl[16] = '{7'h0E, 1'b1, 4'hF, 1'b0, 8'd1};
      tbl[17] = '{7'h7F, 1'b0, 4'hF, 1'b0, 8'd1};
      tbl[18] = '{7'h0E, 1'b1, 4'hF, 1'b0, 8'd1};
      tbl[19] = '{7'h0E, 1'b0, 4'hF, 1'b0, 8'd1};

      bad_pats[0] = 7'h7E;
      bad_pats[1] = 7'h7D;
      bad_pats[2] = 7'h7B;
      bad_pats[3] = 7'h77;
      bad_pats[4] = 7'h6F;

      // ---------------- reset state ----------------
      #2 reset_n = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_bcd",   32'(out_bcd),   0);
      check("rst_err",   32'(out_err),   0);
      check("rst_ecnt",  32'(err_count), 0);
      check("rst_busy",  32'(busy),      0);
      step();
      step();
      reset_n = 1'b1;
      step();
      step();
      check("idle_busy", 32'(busy), 0);

      // ---------------- table of single patterns ----------------
      for (int v = 0; v < 20; v++) begin
         leds      = tbl[v].pat;
         out_ready = 1'b1;
         if (tbl[v].emit) begin
            wait_valid(12, e);
            check($sformatf("v%0d_latency", v), 32'(e), 6);
            check($sformatf("v%0d_bcd", v),  32'(out_bcd),   32'(tbl[v].bcd));
            check($sformatf("v%0d_err", v),  32'(out_err),   32'(tbl[v].err));
            check($sformatf("v%0d_ecnt", v), 32'(err_count), 32'(tbl[v].ecnt));
            step();
            check($sformatf("v%0d_drop", v), 32'(out_valid), 0);
            check($sformatf("v%0d_hold", v), 32'(out_bcd), 32'(tbl[v].bcd));
         end else begin
            seen_v = 0;
            repeat (12) begin
               step();
               if (out_valid) seen_v = 1;
            end
            check($sformatf("v%0d_noemit", v), 32'(seen_v), 0);
            check($sformatf("v%0d_busy", v), 32'(busy), 0);
         end
      end

      // ---------------- back-pressure ----------------
      out_ready = 1'b0;
      leds = 7'h24;
      wait_valid(12, e);
      check("bp_latency", 32'(e), 6);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_valid", 32'(out_valid), 1);
         check("bp_bcd",   32'(out_bcd),   2);
      end
      out_ready = 1'b1;
      step();
      check("bp_drop", 32'(out_valid), 0);
      seen_v = 0;
      repeat (12) begin
         step();
         if (out_valid) seen_v = 1;
      end
      check("bp_no_second", 32'(seen_v), 0);

      // ---------------- glitch returning to the prior pattern ----------------
      leds = 7'h40;
      wait_valid(12, e);
      check("gl_bcd", 32'(out_bcd), 0);
      step();
      leds = 7'h79;
      step();
      step();
      leds = 7'h40;
      seen_v = 0;
      seen_b = 0;
      repeat (14) begin
         step();
         if (out_valid) seen_v = 1;
         if (busy) seen_b = 1;
      end
      check("gl_noemit",  32'(seen_v), 0);
      check("gl_busy_hi", 32'(seen_b), 1);
      check("gl_busy_lo", 32'(busy),   0);

      // ---------------- input change during an offer ----------------
      out_ready = 1'b0;
      leds = 7'h30;
      wait_valid(12, e);
      check("of_bcd", 32'(out_bcd), 3);
      leds = 7'h12;
      repeat (4) step();
      check("of_valid_hold", 32'(out_valid), 1);
      check("of_bcd_hold",   32'(out_bcd),   3);
      out_ready = 1'b1;
      step();
      check("of_drop", 32'(out_valid), 0);
      wait_valid(12, e);
      check("of_next_latency", 32'(e), 5);
      check("of_next_bcd", 32'(out_bcd), 5);
      step();

      // ---------------- error counter saturation (ERR_W=2) ----------------
      for (int i = 0; i < 5; i++) begin
         leds2 = bad_pats[i];
         e = 0;
         for (int k = 1; k <= 12; k++) begin
            step();
            if (valid2) begin
               e = k;
               break;
            end
         end
         check($sformatf("sat%0d_seen", i), 32'(e), 6);
         check($sformatf("sat%0d_err", i),  32'(err2), 1);
         check($sformatf("sat%0d_bcd", i),  32'(bcd2), 0);
         check($sformatf("sat%0d_ecnt", i), 32'(ecnt2), (i < 3) ? i + 1 : 3);
         step();
      end

      // ---------------- reset during an offer ----------------
      out_ready = 1'b0;
      leds = 7'h00;
      wait_valid(12, e);
      check("ro_bcd",  32'(out_bcd),   8);
      check("ro_ecnt", 32'(err_count), 1);
      #2 reset_n = 1'b0;
      #1;
      check("ro_valid", 32'(out_valid), 0);
      check("ro_bcd0",  32'(out_bcd),   0);
      check("ro_err0",  32'(out_err),   0);
      check("ro_ecnt0", 32'(err_count), 0);
      check("ro_busy0", 32'(busy),      0);
      step();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      wait_valid(12, e);
      check("ro_again_latency", 32'(e), 6);
      check("ro_again_bcd", 32'(out_bcd), 8);
      n_emit = (e != 0) ? 1 : 0;
      repeat (20) begin
         step();
         if (out_valid) n_emit++;
      end
      check("ro_once", 32'(n_emit), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
